sram_line_sequencer: RTL
========================

// Module: sram_line_sequencer
// PURPOSE
// Sits between the L2 cache's SRAM-side bus and the single-port 48-bit SRAM controller.
// Turns one 768-bit line request (16 beats x 48 bits) into 16 sequential SRAM beat accesses.
// Reads are pipelined with in-order return; writes are byte-masked.
// Signals one ws_ack per line. This is the line-to-beat bridge that the L2 cache consumes.
// PARAMETERS
// RD_LAT      2   cycles from SRAM beat acceptance to valid sram_dout (1..4)
// SKIP_ZERO   1   1: write beats whose 6-bit mask is all-zero issue no SRAM access
// PORTS
// clk          in   1    clock
// rst          in   1    synchronous, active-high reset
// ws_addr      in   32   line address; bits [5:0] ignored (64-byte aligned line)
// ws_din       in   768  write line; beat i = [i*48+47:i*48]
// ws_dm        in   96   byte-write mask; beat i = [i*6+5:i*6]
// ws_stb       in   1    request strobe; one-cycle pulse; sampled only in IDLE
// ws_we        in   1    1 = write line, 0 = read line
// ws_ack       out  1    one-cycle completion pulse
// ws_dout      out  768  read line; held stable until next read completes
// sram_addr    out  32   beat address = {ws_addr[31:6], beat[3:0], 2'b00}
// sram_din     out  48   beat write data
// sram_dm      out  6    beat byte-write mask; 0 for reads
// sram_stb     out  1    beat request
// sram_nak     in   1    SRAM busy; beat is accepted when sram_stb && !sram_nak
// sram_dout    in   48   read data, valid exactly RD_LAT cycles after acceptance
// BEHAVIOUR
// - Reset: ws_ack=0, ws_dout=0, sram_stb=0, sram_dm=0, sram_addr=0, sram_din=0.
//   Reset also clears the state, counters and the return pipe.
// - Reset mid-line aborts the line with no ack; in-flight sram_dout is discarded.
// - Request capture: in IDLE, when ws_stb=1, latch addr/din/dm/we and go to ISSUE next cycle.
//   Any ws_stb outside IDLE is ignored.
// - States: IDLE -> ISSUE -> (read: DRAIN) -> ACK -> IDLE.
// - ISSUE: issue index k (0..15) drives sram_addr, sram_din=beat k, sram_dm=dm beat k
//   (reads: 0), with sram_stb=1.
//   - sram_nak=1: hold all sram_* outputs unchanged; k does not advance.
//   - Accepted beat: k+1 is presented the next cycle, so there are no bubbles on back-to-back accepts.
//   - SKIP_ZERO=1 and write beat mask==0: skip k with sram_stb=0 for that beat. Skipping advances
//     to the next non-zero beat in the same cycle (priority search over the remaining beats).
//   - After beat 15 is accepted or skipped, sram_stb drops to 0 in the next cycle.
//     Writes then go to ACK; reads go to DRAIN.
// - Read return: an RD_LAT-deep valid shift register tags accepted read beats.
//   - A tag emerging at depth RD_LAT writes sram_dout into ws_dout beat r; then r++.
//   - ws_dout updates per beat. It is not guaranteed coherent until ws_ack.
// - DRAIN: wait until r==16, then go to ACK.
// - ACK: ws_ack=1 for exactly one cycle, then IDLE. A new ws_stb is sampled in the cycle after ws_ack.
// - Latency with no nak: write = 18 cycles from ws_stb to ws_ack; read = 17+RD_LAT cycles.
// - Write with all-zero ws_dm and SKIP_ZERO=1: no SRAM access; ws_ack 2 cycles after ws_stb.
// - Counters: k and r are 5 bits; 16 = terminal. Beat address wraps only in bits [5:2].
// - nak is asserted only while sram_stb=1. nak does not stall the return pipe: data already
//   accepted always returns.
// STRUCTURE
// - Shared package sram_line_pkg holds:
//   - BEATS=16, BEAT_W=48, DM_W=6, LINE_W=768
//   - state encoding ST_IDLE/ST_ISSUE/ST_DRAIN/ST_ACK
//   - function beat_addr(line_addr, idx)
// - One sub-module, sram_rd_tracker: RD_LAT-deep valid pipe plus return counter r. Outputs are the
//   capture strobe, the beat index and done.
// TESTING
// 1. Read, no nak, RD_LAT=2, SRAM model returns 48'h000A_0000_0000+i for beat i ->
//    ws_dout beat i matches; ws_ack exactly 19 cycles after ws_stb.
// 2. Write 0x00400040, ws_dm all-ones, beat i data=i -> 16 accesses at sram_addr 0x00400040..0x0040007C
//    step 4, sram_dm=6'h3F; ws_ack at cycle 18.
// 3. Read with sram_nak=1 on beats 3 and 7 for 4 cycles each -> sram_addr/stb held while nak;
//    no duplicate beats; data order intact; ack 8 cycles later than scenario 1.
// 4. Write with ws_dm beats 0,5,15 non-zero only, SKIP_ZERO=1 -> exactly 3 SRAM accesses with the
//    correct masks; all-zero-mask write -> no sram_stb, ack at cycle 2.
// 5. ws_stb pulsed mid-ISSUE -> ignored; single ws_ack for the first request; sram traffic unchanged.
// 6. rst asserted at beat 6 of a read -> next cycle sram_stb=0, ws_ack=0, ws_dout=0; late sram_dout
//    ignored; a fresh read then completes correctly.

Source files
------------

// File: rtl/sram_line_pkg.sv
// Shared geometry, state encoding and address helper for the L2 line-to-SRAM-beat bridge.
package sram_line_pkg;

  localparam int BEATS     = 16;
  localparam int BEAT_W    = 48;
  localparam int DM_W      = 6;
  localparam int LINE_W    = BEATS * BEAT_W;
  localparam int DM_LINE_W = BEATS * DM_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_ACK
  } state_t;

  // Beat address keeps the 64-byte line tag; only bits [5:2] walk across the line.
  function automatic logic [31:0] beat_addr(input logic [25:0] line_tag,
                                            input logic [3:0]  idx);
    return {line_tag, idx, 2'b00};
  endfunction

endpackage

// File: rtl/sram_rd_tracker.sv
// Tags accepted read beats through an RD_LAT-deep valid pipe and counts returned beats.
module sram_rd_tracker
  import sram_line_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  output logic       cap,
  output logic [3:0] idx,
  output logic       done
);

  logic [RD_LAT-1:0] vld_p;
  logic [4:0]        r;

  // Stage boundary: one valid bit per cycle of SRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= push;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r <= '0;
    end else if (cap && !r[4]) begin
      r <= r + 5'd1;
    end
  end

  assign cap  = vld_p[RD_LAT-1];
  assign idx  = r[3:0];
  // Looks one capture ahead so the sequencer can leave DRAIN as the last beat lands.
  assign done = r[4] || (cap && (r == 5'd15));

endmodule

// File: rtl/sram_line_sequencer.sv
// Bridges one 768-bit L2 line request to sixteen 48-bit SRAM beats with in-order read return.
module sram_line_sequencer
  import sram_line_pkg::*;
#(
  parameter int RD_LAT    = 2,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ws_addr,
  input  logic [LINE_W-1:0]    ws_din,
  input  logic [DM_LINE_W-1:0] ws_dm,
  input  logic                 ws_stb,
  input  logic                 ws_we,
  output logic                 ws_ack,
  output logic [LINE_W-1:0]    ws_dout,
  output logic [31:0]          sram_addr,
  output logic [BEAT_W-1:0]    sram_din,
  output logic [DM_W-1:0]      sram_dm,
  output logic                 sram_stb,
  input  logic                 sram_nak,
  input  logic [BEAT_W-1:0]    sram_dout
);

  state_t                 state, state_nxt;
  logic [4:0]             k, k_nxt;
  logic [4:0]             e;
  logic [3:0]             ei;
  logic                   issue_vld;
  logic                   accept;
  logic                   skip_en;
  logic                   start;
  logic [25:0]            line_tag;
  logic [LINE_W-1:0]      line_din;
  logic [DM_LINE_W-1:0]   line_dm;
  logic                   line_we;
  logic                   rd_cap;
  logic [3:0]             rd_idx;
  logic                   rd_done;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^ws_addr[5:0];
  assign start           = (state == ST_IDLE) && ws_stb;
  assign skip_en         = SKIP_ZERO && line_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Request capture: the line is held for the whole transaction.
  always_ff @(posedge clk) begin
    if (start) begin
      line_tag <= ws_addr[31:6];
      line_din <= ws_din;
      line_dm  <= ws_dm;
      line_we  <= ws_we;
    end
  end

  // Priority search for the first beat at or after k that needs an SRAM access; 16 = none left.
  always_comb begin
    e = 5'd16;
    for (int i = BEATS - 1; i >= 0; i--) begin
      if ((5'(i) >= k) && (!skip_en || (line_dm[i*DM_W +: DM_W] != '0))) e = 5'(i);
    end
  end

  assign ei        = e[3:0];
  assign issue_vld = (state == ST_ISSUE) && !e[4];
  assign accept    = sram_stb && !sram_nak;

  always_comb begin
    sram_stb  = issue_vld;
    sram_addr = '0;
    sram_din  = '0;
    sram_dm   = '0;
    if (issue_vld) begin
      sram_addr = beat_addr(line_tag, ei);
      sram_din  = line_din[int'(ei)*BEAT_W +: BEAT_W];
      sram_dm   = line_we ? line_dm[int'(ei)*DM_W +: DM_W] : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    ws_ack    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ws_stb) begin
          state_nxt = ST_ISSUE;
          k_nxt     = '0;
        end
      end
      ST_ISSUE: begin
        // A nak leaves k parked on the presented beat so the outputs hold.
        k_nxt = accept ? (e + 5'd1) : e;
        if (e[4]) state_nxt = (line_we || rd_done) ? ST_ACK : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rd_done) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        ws_ack    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sram_rd_tracker #(
    .RD_LAT(RD_LAT)
  ) u_rd_tracker (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .push(accept && !line_we),
    .cap (rd_cap),
    .idx (rd_idx),
    .done(rd_done)
  );

  // Return stage: each tagged beat lands in its slot of the read line.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_dout <= '0;
    end else if (rd_cap) begin
      ws_dout[int'(rd_idx)*BEAT_W +: BEAT_W] <= sram_dout;
    end
  end

endmodule
